// File: rtl/instruction_fetch.sv
// Instruction fetch stage: requests words from instruction memory and presents a PC/instruction bundle to IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds a consumed-instruction counter on fetch_count.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] PC_out_IF,
    output logic [15:0] PC_plus1_out_IF,
    output logic [15:0] Instruction_out_IF,
    output logic        Valid_out_IF,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drain_addr_q, drain_addr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] pc_plus1_q, pc_plus1_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        consume;
    logic        hold;
    logic        ack_take;

    assign consume  = valid_q && !stall;
    assign hold     = valid_q && stall;
    assign ack_take = imem_req && imem_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect that catches a request mid-flight must wait out its ack before refetching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (redirect_valid && imem_req && !imem_ack) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            FETCH: begin
                imem_req  = reset_n && !hold;
                imem_addr = pc_q;
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc_q;
            end
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pc_out_d     = pc_out_q;
        pc_plus1_d   = pc_plus1_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        drain_addr_d = (state_q == FETCH) ? pc_q : drain_addr_q;

        if (redirect_valid) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
            instr_d = 16'hFFFF;
        end else if ((state_q == FETCH) && ack_take) begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus1_d = pc_q + 16'd1;
            valid_d    = 1'b1;
            pc_d       = pc_q + 16'd1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            pc_out_q     <= 16'h0000;
            pc_plus1_q   <= 16'h0000;
            instr_q      <= 16'hFFFF;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pc_out_q     <= pc_out_d;
            pc_plus1_q   <= pc_plus1_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    assign PC_out_IF          = pc_out_q;
    assign PC_plus1_out_IF    = pc_plus1_q;
    assign Instruction_out_IF = instr_q;
    assign Valid_out_IF       = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] count_q, count_d;

    assign count_d = consume ? count_q + 16'd1 : count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, drain/wrap sequences, and
// randomized stall/redirect/latency traffic scored against a consumed-stream model.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        resetN;
    logic        stall;
    logic        redirectValid;
    logic [15:0] redirectTarget;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemRdata;
    logic [15:0] pcOut, pcPlus1, instrOut, fetchCount;
    logic        validOut;

    logic        noStall = 1'b0;
    logic        noRedirect = 1'b0;
    logic [15:0] noTarget = 16'h0000;
    logic        imemReq2;
    logic [15:0] imemAddr2;
    logic        imemAck2;
    logic [15:0] imemRdata2;
    logic [15:0] pcOut2, pcPlus1_2, instrOut2, fetchCount2;
    logic        validOut2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    instruction_fetch dut (
        .clock(clock), .reset_n(resetN), .stall(stall),
        .redirect_valid(redirectValid), .redirect_target(redirectTarget),
        .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
        .PC_out_IF(pcOut), .PC_plus1_out_IF(pcPlus1), .Instruction_out_IF(instrOut),
        .Valid_out_IF(validOut), .fetch_count(fetchCount)
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) dutWrap (
        .clock(clock), .reset_n(resetN), .stall(noStall),
        .redirect_valid(noRedirect), .redirect_target(noTarget),
        .imem_req(imemReq2), .imem_addr(imemAddr2), .imem_ack(imemAck2), .imem_rdata(imemRdata2),
        .PC_out_IF(pcOut2), .PC_plus1_out_IF(pcPlus1_2), .Instruction_out_IF(instrOut2),
        .Valid_out_IF(validOut2), .fetch_count(fetchCount2)
    );

    // Memory answers with 16'h1000+addr after memLat cycles of a held request.
    int memWait;
    int memLat;
    int memMaxLat = 0;
    bit memRandLat = 1'b0;

    assign imemAck   = imemReq && (memWait >= memLat);
    assign imemRdata = imemAck ? 16'h1000 + imemAddr : 16'hDEAD;
    assign imemAck2  = imemReq2;
    assign imemRdata2 = 16'h1000 + imemAddr2;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            memWait <= 0;
            memLat  <= memMaxLat;
        end else if (imemAck) begin
            memWait <= 0;
            memLat  <= memRandLat ? int'($urandom_range(memMaxLat, 0)) : memMaxLat;
        end else if (imemReq) begin
            memWait <= memWait + 1;
        end else begin
            memWait <= 0;
        end
    end

    function automatic logic [15:0] expCount(input int n);
`ifdef FETCH_PERF_CNT_EN
        return 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic applyStimulus(input logic s, input logic rv, input logic [15:0] rt);
        stall          = s;
        redirectValid  = rv;
        redirectTarget = rt;
    endtask

    task automatic applyReset();
        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clock);
        checkBit("rst valid", validOut, 1'b0);
        checkBit("rst req", imemReq, 1'b0);
        checkOutput("rst instr", instrOut, 16'hFFFF);
        checkOutput("rst pc", pcOut, 16'h0000);
        checkOutput("rst pc1", pcPlus1, 16'h0000);
        checkOutput("rst count", fetchCount, 16'h0000);
        checkBit("rst req2", imemReq2, 1'b0);
        checkOutput("rst instr2", instrOut2, 16'hFFFF);
        @(posedge clock);
        #1 resetN = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        rv;
        logic [15:0] rt;
        logic        eValid;
        logic [15:0] ePc;
        logic [15:0] eP1;
        logic [15:0] eInstr;
        logic        eReq;
        logic [15:0] eAddr;
    } vec_t;

    vec_t vecs[19];

    logic        found, ackSeen, validSeen;
    logic [15:0] expPc;
    int          consumed;
    logic        prevValid, prevStall, prevRedirect, prevReq, prevAck;
    logic [15:0] prevAddr, prevPc, prevP1, prevInstr;
    logic [15:0] rndTarget;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0001, 16'h1000, 1'b1, 16'h0001};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0002, 16'h1001, 1'b1, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h0003, 16'h1002, 1'b1, 16'h0003};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0004, 16'h1003, 1'b1, 16'h0004};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0005, 16'h1004, 1'b1, 16'h0005};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0006, 16'h1005, 1'b0, 16'h0006};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0006, 16'h1005, 1'b0, 16'h0006};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0006, 16'h1005, 1'b0, 16'h0006};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0006, 16'h1005, 1'b1, 16'h0006};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h0007, 16'h1006, 1'b1, 16'h0007};
        vecs[11] = '{1'b0, 1'b1, 16'h0040, 1'b1, 16'h0007, 16'h0008, 16'h1007, 1'b1, 16'h0008};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0007, 16'h0008, 16'hFFFF, 1'b1, 16'h0040};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 16'h0041, 16'h1040, 1'b1, 16'h0041};
        vecs[14] = '{1'b1, 1'b1, 16'h0100, 1'b1, 16'h0041, 16'h0042, 16'h1041, 1'b0, 16'h0042};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0041, 16'h0042, 16'hFFFF, 1'b1, 16'h0100};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 16'h0101, 16'h1100, 1'b0, 16'h0101};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 16'h0101, 16'h1100, 1'b1, 16'h0101};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 16'h0102, 16'h1101, 1'b1, 16'h0102};

        memMaxLat  = 0;
        memRandLat = 1'b0;
        applyReset();

        // Wrap-around instance: RESET_PC=FFFE with an always-acking memory and no stalls.
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checkOutput($sformatf("wrap%0d count", k), fetchCount2, expCount(k < 2 ? 0 : k - 1));
            if (k == 0) begin
                checkBit("wrap0 valid", validOut2, 1'b0);
                checkOutput("wrap0 addr", imemAddr2, 16'hFFFE);
            end else if (k <= 3) begin
                checkBit($sformatf("wrap%0d valid", k), validOut2, 1'b1);
                checkOutput($sformatf("wrap%0d pc", k), pcOut2, 16'hFFFE + 16'(k - 1));
                checkOutput($sformatf("wrap%0d pc1", k), pcPlus1_2, 16'hFFFF + 16'(k - 1));
                checkOutput($sformatf("wrap%0d instr", k), instrOut2, 16'h1000 + 16'hFFFE + 16'(k - 1));
            end
            @(posedge clock);
            #1;
        end

        applyReset();
        consumed = 0;
        for (int k = 0; k < 19; k++) begin
            applyStimulus(vecs[k].stall, vecs[k].rv, vecs[k].rt);
            @(negedge clock);
            checkBit($sformatf("vec%0d valid", k), validOut, vecs[k].eValid);
            checkOutput($sformatf("vec%0d pc", k), pcOut, vecs[k].ePc);
            checkOutput($sformatf("vec%0d pc1", k), pcPlus1, vecs[k].eP1);
            checkOutput($sformatf("vec%0d instr", k), instrOut, vecs[k].eInstr);
            checkBit($sformatf("vec%0d req", k), imemReq, vecs[k].eReq);
            checkOutput($sformatf("vec%0d addr", k), imemAddr, vecs[k].eAddr);
            checkOutput($sformatf("vec%0d count", k), fetchCount, expCount(consumed));
            if (vecs[k].eValid && !vecs[k].stall) consumed++;
            @(posedge clock);
            #1;
        end

        // Redirect while a 3-cycle request for PC=3 is outstanding.
        memMaxLat = 3;
        applyReset();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000);
            @(negedge clock);
            if (imemReq && imemAddr == 16'h0003) begin
                found = 1'b1;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        checkBit("drain req3 seen", found, 1'b1);
        if (found) begin
            @(posedge clock);
            #1 applyStimulus(1'b0, 1'b1, 16'h0040);
            @(negedge clock);
            checkBit("drain redir req", imemReq, 1'b1);
            checkOutput("drain redir addr", imemAddr, 16'h0003);
            checkBit("drain redir ack", imemAck, 1'b0);
            @(posedge clock);
            #1 applyStimulus(1'b0, 1'b0, 16'h0000);
            ackSeen = 1'b0;
            for (int c = 0; c < 10 && !ackSeen; c++) begin
                @(negedge clock);
                checkBit("drain valid", validOut, 1'b0);
                checkBit("drain req", imemReq, 1'b1);
                checkOutput("drain addr", imemAddr, 16'h0003);
                if (imemAck) begin
                    ackSeen = 1'b1;
                end else begin
                    @(posedge clock);
                    #1;
                end
            end
            checkBit("drain ack seen", ackSeen, 1'b1);
            @(posedge clock);
            #1;
            @(negedge clock);
            checkBit("drain after valid", validOut, 1'b0);
            checkBit("drain after req", imemReq, 1'b1);
            checkOutput("drain after addr", imemAddr, 16'h0040);
            validSeen = 1'b0;
            for (int c = 0; c < 10 && !validSeen; c++) begin
                @(posedge clock);
                #1;
                @(negedge clock);
                validSeen = validOut;
            end
            checkBit("drain bundle seen", validSeen, 1'b1);
            checkOutput("drain bundle pc", pcOut, 16'h0040);
            checkOutput("drain bundle instr", instrOut, 16'h1040);
            @(posedge clock);
            #1;
        end

        // Random traffic: every consumed bundle must continue the expected PC stream.
        memMaxLat  = 3;
        memRandLat = 1'b1;
        applyReset();
        expPc        = 16'h0000;
        consumed     = 0;
        prevValid    = 1'b0;
        prevStall    = 1'b0;
        prevRedirect = 1'b0;
        prevReq      = 1'b0;
        prevAck      = 1'b0;
        prevAddr     = 16'h0000;
        prevPc       = 16'h0000;
        prevP1       = 16'h0000;
        prevInstr    = 16'hFFFF;
        for (int i = 0; i < 2000; i++) begin
            rndTarget = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                    : 16'($urandom);
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, rndTarget);
            @(negedge clock);
            if (prevRedirect) begin
                checkBit("rnd redir valid", validOut, 1'b0);
                checkOutput("rnd redir instr", instrOut, 16'hFFFF);
            end else if (prevValid && prevStall) begin
                checkBit("rnd hold valid", validOut, 1'b1);
                checkOutput("rnd hold pc", pcOut, prevPc);
                checkOutput("rnd hold pc1", pcPlus1, prevP1);
                checkOutput("rnd hold instr", instrOut, prevInstr);
            end
            if (prevReq && !prevAck) begin
                checkBit("rnd req held", imemReq, 1'b1);
                checkOutput("rnd addr stable", imemAddr, prevAddr);
            end
            checkBit("rnd req rule", imemReq, !(validOut && stall));
            checkOutput("rnd count", fetchCount, expCount(consumed));
            if (validOut && !stall) begin
                checkOutput("rnd pc", pcOut, expPc);
                checkOutput("rnd pc1", pcPlus1, expPc + 16'd1);
                checkOutput("rnd instr", instrOut, 16'h1000 + expPc);
                expPc = expPc + 16'd1;
                consumed++;
            end
            if (redirectValid) expPc = redirectTarget;
            prevValid    = validOut;
            prevStall    = stall;
            prevRedirect = redirectValid;
            prevReq      = imemReq;
            prevAck      = imemAck;
            prevAddr     = imemAddr;
            prevPc       = pcOut;
            prevP1       = pcPlus1;
            prevInstr    = instrOut;
            @(posedge clock);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
